// File: rtl/sdram_requester_pkg.sv
// Shared definitions for the CPU-side SDRAM requester and its controller:
// bus widths, parameter defaults, one-hot FSM state encoding, the command
// payload and a saturating-increment helper.
package sdram_requester_pkg;

  localparam int unsigned ADDR_W          = 22;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned ERR_CNT_W       = 8;
  localparam int unsigned TIMEOUT_DEFAULT = 1023;
  localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hffff_ffff;

  // One-hot so each request output is a single state bit.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_RD_REQ = 4'b0010,
    ST_WR_REQ = 4'b0100,
    ST_REL    = 4'b1000
  } state_e;

  // Command payload as presented by the CPU datapath.
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  // Increment that sticks at all-ones.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/sdram_requester_if.sv
// SDRAM level-handshake bus between the CPU requester and the RAM controller.
//   sdram_addr, sdram_data_in : registered address / write data (requester -> controller)
//   sdram_req, sdram_write    : read / write request levels      (requester -> controller)
//   sdram_data_out            : read data                        (controller -> requester)
//   sdram_ready, sdram_done   : read / write acknowledge levels  (controller -> requester)
interface sdram_requester_if;
  import sdram_requester_pkg::*;

  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] sdram_data_in;
  logic              sdram_req;
  logic              sdram_write;
  logic [DATA_W-1:0] sdram_data_out;
  logic              sdram_ready;
  logic              sdram_done;

  modport master (
    output sdram_addr, sdram_data_in, sdram_req, sdram_write,
    input  sdram_data_out, sdram_ready, sdram_done
  );

  modport slave (
    input  sdram_addr, sdram_data_in, sdram_req, sdram_write,
    output sdram_data_out, sdram_ready, sdram_done
  );

endinterface

// File: rtl/sdram_req_timer.sv
// Request timeout counter.
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero the count (asserted on command accept)
//   enable     : count this cycle (request outstanding)
//   expired_c  : combinational, count has reached TIMEOUT while enabled
// The count stops at TIMEOUT and never wraps.
module sdram_req_timer
  import sdram_requester_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up to the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_c = enable && (cnt_q == CNT_MAX);

endmodule

// File: rtl/sdram_requester.sv
// CPU-side initiator for the SDRAM level handshake. Accepts one command at a
// time, holds address/data stable, raises sdram_req or sdram_write until the
// controller acknowledges (or the timer expires), then waits for the
// acknowledge to fall before taking the next command.
//   clk, reset          : CPU clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake; cmd_write, cmd_addr, cmd_wdata payload
//   rsp_valid           : one-cycle completion strobe, qualified by rsp_error
//   rsp_rdata           : read data (ERR_DATA on read timeout), held between strobes
//   busy                : FSM not idle
//   err_count           : saturating timeout count
//   sdram               : master side of the SDRAM handshake bus
module sdram_requester
  import sdram_requester_pkg::*;
#(
  parameter int unsigned       TIMEOUT  = TIMEOUT_DEFAULT,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [DATA_W-1:0]    cmd_wdata,
  output logic                 rsp_valid,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_error,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count,
  sdram_requester_if.master    sdram
);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;
  logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
  logic                  busy_q, busy_d;

  cmd_t cmd_c;
  logic timer_clear_c;
  logic timer_en_c;
  logic timer_expired_c;

  assign cmd_c = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

  // A stale acknowledge from the previous operation blocks new commands.
  assign cmd_ready  = (state_q == ST_IDLE) && !sdram.sdram_ready && !sdram.sdram_done;
  assign timer_en_c = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);

  sdram_req_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (timer_clear_c),
    .enable    (timer_en_c),
    .expired_c (timer_expired_c)
  );

  // Next-state and response logic; acknowledge takes priority over timeout.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_error_d   = 1'b0;
    err_count_d   = err_count_q;
    timer_clear_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d        = cmd_c.addr;
          wdata_d       = cmd_c.wdata;
          timer_clear_c = 1'b1;
          state_d       = cmd_c.write ? ST_WR_REQ : ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (sdram.sdram_ready) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = sdram.sdram_data_out;
          state_d     = ST_REL;
        end else if (timer_expired_c) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          rsp_rdata_d = ERR_DATA;
          err_count_d = sat_inc(err_count_q);
          state_d     = ST_REL;
        end
      end
      ST_WR_REQ: begin
        if (sdram.sdram_done) begin
          rsp_valid_d = 1'b1;
          state_d     = ST_REL;
        end else if (timer_expired_c) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          err_count_d = sat_inc(err_count_q);
          state_d     = ST_REL;
        end
      end
      ST_REL: begin
        if (!sdram.sdram_ready && !sdram.sdram_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      err_count_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      err_count_q <= err_count_d;
      busy_q      <= busy_d;
    end
  end

  // Request levels are pure state decodes.
  assign sdram.sdram_req     = (state_q == ST_RD_REQ);
  assign sdram.sdram_write   = (state_q == ST_WR_REQ);
  assign sdram.sdram_addr    = addr_q;
  assign sdram.sdram_data_in = wdata_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign err_count = err_count_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sdram_requester.sv
// Self-checking bench for sdram_requester with a cycle-level responder driven
// from the scenario tasks and a transaction-level reference model.
module tb_sdram_requester;
  import sdram_requester_pkg::*;

  localparam int unsigned TO = 15;
  localparam logic [DATA_W-1:0] ERRD = 32'hffff_ffff;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_write;
  logic [ADDR_W-1:0]    cmd_addr;
  logic [DATA_W-1:0]    cmd_wdata;
  logic                 rsp_valid;
  logic [DATA_W-1:0]    rsp_rdata;
  logic                 rsp_error;
  logic                 busy;
  logic [ERR_CNT_W-1:0] err_count;

  sdram_requester_if sdram_bus ();

  sdram_requester #(
    .TIMEOUT  (TO),
    .ERR_DATA (ERRD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .busy      (busy),
    .err_count (err_count),
    .sdram     (sdram_bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: last returned read data and timeout count.
  int          m_err_count = 0;
  logic [31:0] m_rdata     = 32'h0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction. delay = cycles after the request rises before the
  // acknowledge is raised (beyond TO means never); hold = extra cycles the
  // acknowledge stays high after the response. The nv/nw/na/nd command is
  // presented from the response cycle onward (nv=0: cmd_valid drops).
  task automatic do_txn(input logic w, input logic [21:0] a, input logic [31:0] d,
                        input int delay, input int hold,
                        input logic nv, input logic nw, input logic [21:0] na,
                        input logic [31:0] nd);
    int          waited;
    int          exp_resp;
    int          rel_end;
    int          req_cycles;
    logic        ok;
    logic        ack;
    logic [31:0] exp_rd;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    #1;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 64) begin
      step();
      waited++;
    end
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL accept_wait: cmd_ready=%b required 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    ok         = (delay <= int'(TO));
    exp_resp   = ok ? delay + 1 : int'(TO) + 1;
    rel_end    = ok ? exp_resp + hold : exp_resp;
    exp_rd     = m_rdata;
    req_cycles = 0;
    step();
    cmd_valid = 1'b0;
    for (int c = 0; c <= rel_end + 1; c++) begin
      tests++;
      if (sdram_bus.sdram_addr !== a || sdram_bus.sdram_data_in !== d) begin
        fails++;
        $display("FAIL hold_addr_data c=%0d: addr=%h data=%h required %h %h",
                 c, sdram_bus.sdram_addr, sdram_bus.sdram_data_in, a, d);
      end
      if (sdram_bus.sdram_req === 1'b1 || sdram_bus.sdram_write === 1'b1) req_cycles++;
      if (c < exp_resp) begin
        tests++;
        if (sdram_bus.sdram_req !== !w || sdram_bus.sdram_write !== w ||
            rsp_valid !== 1'b0 || busy !== 1'b1) begin
          fails++;
          $display("FAIL request_phase c=%0d: req=%b wr=%b rsp_valid=%b busy=%b required %b %b 0 1",
                   c, sdram_bus.sdram_req, sdram_bus.sdram_write, rsp_valid, busy, !w, w);
        end
      end else if (c == exp_resp) begin
        if (!ok && m_err_count < 255) m_err_count++;
        if (!w) m_rdata = ok ? exp_rd : ERRD;
        tests++;
        if (rsp_valid !== 1'b1 || rsp_error !== !ok || rsp_rdata !== m_rdata ||
            err_count !== 8'(m_err_count)) begin
          fails++;
          $display("FAIL response c=%0d: valid=%b err=%b rdata=%h errcnt=%0d required 1 %b %h %0d",
                   c, rsp_valid, rsp_error, rsp_rdata, err_count, !ok, m_rdata, m_err_count);
        end
        tests++;
        if (sdram_bus.sdram_req !== 1'b0 || sdram_bus.sdram_write !== 1'b0) begin
          fails++;
          $display("FAIL req_drop c=%0d: req=%b wr=%b required 0 0",
                   c, sdram_bus.sdram_req, sdram_bus.sdram_write);
        end
      end else if (c <= rel_end) begin
        tests++;
        if (rsp_valid !== 1'b0 || sdram_bus.sdram_req !== 1'b0 || sdram_bus.sdram_write !== 1'b0 ||
            cmd_ready !== 1'b0 || busy !== 1'b1) begin
          fails++;
          $display("FAIL release_wait c=%0d: valid=%b req=%b wr=%b cmd_ready=%b busy=%b required 0 0 0 0 1",
                   c, rsp_valid, sdram_bus.sdram_req, sdram_bus.sdram_write, cmd_ready, busy);
        end
      end else begin
        tests++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
          fails++;
          $display("FAIL back_to_idle c=%0d: busy=%b cmd_ready=%b valid=%b required 0 1 0",
                   c, busy, cmd_ready, rsp_valid);
        end
        break;
      end
      // Inputs for cycle c.
      sdram_bus.sdram_data_out = $urandom;
      if (c == delay) exp_rd = sdram_bus.sdram_data_out;
      ack = (c < exp_resp) ? (c >= delay) : (ok && c < exp_resp + hold);
      sdram_bus.sdram_ready = ack && !w;
      sdram_bus.sdram_done  = ack && w;
      if (c == exp_resp) begin
        cmd_valid = nv;
        cmd_write = nw;
        cmd_addr  = na;
        cmd_wdata = nd;
      end
      step();
    end
    tests++;
    if (req_cycles != exp_resp) begin
      fails++;
      $display("FAIL req_length: %0d cycles required %0d", req_cycles, exp_resp);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    sdram_bus.sdram_ready    = 1'b0;
    sdram_bus.sdram_done     = 1'b0;
    sdram_bus.sdram_data_out = '0;
    repeat (3) step();
    tests++;
    if (sdram_bus.sdram_req !== 1'b0 || sdram_bus.sdram_write !== 1'b0 ||
        sdram_bus.sdram_addr !== '0 || sdram_bus.sdram_data_in !== '0) begin
      fails++;
      $display("FAIL reset_bus: req=%b wr=%b addr=%h data=%h required all 0",
               sdram_bus.sdram_req, sdram_bus.sdram_write, sdram_bus.sdram_addr, sdram_bus.sdram_data_in);
    end
    tests++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_error !== 1'b0 ||
        err_count !== '0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_rsp: valid=%b rdata=%h err=%b errcnt=%0d busy=%b required all 0",
               rsp_valid, rsp_rdata, rsp_error, err_count, busy);
    end
    reset = 1'b0;
    step();
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_cmd_ready: %b required 1", cmd_ready);
    end
    m_err_count = 0;
    m_rdata     = 32'h0;
  endtask

  task automatic test_read();
    sdram_bus.sdram_data_out = 32'hdeadbeef;
    do_txn(1'b0, 22'h00010, 32'h0, 3, 1, 1'b0, 1'b0, 22'h0, 32'h0);
  endtask

  task automatic test_write();
    do_txn(1'b1, 22'h00020, 32'h12345678, 5, 1, 1'b0, 1'b0, 22'h0, 32'h0);
  endtask

  task automatic test_back_to_back();
    do_txn(1'b0, 22'h00100, 32'h0, 2, 2, 1'b1, 1'b1, 22'h00200, 32'hcafef00d);
    do_txn(1'b1, 22'h00200, 32'hcafef00d, 1, 2, 1'b0, 1'b0, 22'h0, 32'h0);
  endtask

  task automatic test_ack_at_timeout();
    do_txn(1'b0, 22'h00abc, 32'h0, int'(TO), 1, 1'b0, 1'b0, 22'h0, 32'h0);
  endtask

  task automatic test_stale_ack();
    sdram_bus.sdram_done = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 22'h00333;
    cmd_wdata = 32'h0badf00d;
    #1;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (cmd_ready !== 1'b0 || sdram_bus.sdram_write !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL stale_ack i=%0d: cmd_ready=%b wr=%b busy=%b required 0 0 0",
                 i, cmd_ready, sdram_bus.sdram_write, busy);
      end
      step();
    end
    sdram_bus.sdram_done = 1'b0;
    do_txn(1'b1, 22'h00333, 32'h0badf00d, 4, 1, 1'b0, 1'b0, 22'h0, 32'h0);
  endtask

  task automatic test_timeout();
    do_txn(1'b0, 22'h00444, 32'h0, 1000, 0, 1'b0, 1'b0, 22'h0, 32'h0);
    tests++;
    if (err_count !== 8'd1 || rsp_rdata !== ERRD) begin
      fails++;
      $display("FAIL timeout_first: errcnt=%0d rdata=%h required 1 ffffffff", err_count, rsp_rdata);
    end
    for (int i = 0; i < 299; i++) begin
      do_txn(1'($urandom_range(0, 1)), 22'($urandom), $urandom,
             int'(TO) + 1 + int'($urandom_range(0, 4)), 0, 1'b0, 1'b0, 22'h0, 32'h0);
    end
    tests++;
    if (err_count !== 8'd255) begin
      fails++;
      $display("FAIL timeout_saturate: errcnt=%0d required 255", err_count);
    end
  endtask

  task automatic test_mid_reset();
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 22'h00555;
    cmd_wdata = 32'h0;
    #1;
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_accept: cmd_ready=%b required 1", cmd_ready);
    end
    step();
    cmd_valid = 1'b0;
    tests++;
    if (sdram_bus.sdram_req !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_req: req=%b required 1", sdram_bus.sdram_req);
    end
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    sdram_bus.sdram_ready = 1'b1;
    m_err_count = 0;
    m_rdata     = 32'h0;
    tests++;
    if (sdram_bus.sdram_req !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
        err_count !== 8'(m_err_count) || rsp_rdata !== m_rdata) begin
      fails++;
      $display("FAIL mid_reset_drop: req=%b valid=%b busy=%b errcnt=%0d rdata=%h required 0 0 0 %0d %h",
               sdram_bus.sdram_req, rsp_valid, busy, err_count, rsp_rdata, m_err_count, m_rdata);
    end
    #1;
    tests++;
    if (cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_stale: cmd_ready=%b required 0", cmd_ready);
    end
    step();
    sdram_bus.sdram_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
        fails++;
        $display("FAIL mid_reset_idle i=%0d: cmd_ready=%b valid=%b required 1 0", i, cmd_ready, rsp_valid);
      end
      step();
    end
  endtask

  task automatic test_random();
    logic        cw, nw, nv;
    logic [21:0] ca, na;
    logic [31:0] cd, nd;
    cw = 1'($urandom_range(0, 1));
    ca = 22'($urandom);
    cd = $urandom;
    for (int i = 0; i < 40; i++) begin
      nv = 1'($urandom_range(0, 1));
      nw = 1'($urandom_range(0, 1));
      na = 22'($urandom);
      nd = $urandom;
      do_txn(cw, ca, cd, int'($urandom_range(0, 20)), int'($urandom_range(0, 3)), nv, nw, na, nd);
      cw = nw;
      ca = na;
      cd = nd;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_ack_at_timeout();
    test_stale_ack();
    test_timeout();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
